wb_rr_interconnect: RTL

Parametrised shared-bus Wishbone classic interconnect and the successor to the fixed 2-master/3-slave interconnect.
- NM masters, NS slaves, round-robin arbitration.
- Address-field decode to slaves; Wishbone error response for unmapped addresses.
- Optional watchdog timeout for stalled slaves.
- Sits between the CPU/DMA masters and the SRAM adapter and peripheral bridges in the SoC core.

---
 rtl/wb_rr_interconnect_pkg.sv | 25 ++
 rtl/wb_rr_arbiter.sv | 45 ++++
 rtl/wb_rr_interconnect.sv | 139 +++++++++++++
 3 files changed

// File: rtl/wb_rr_interconnect_pkg.sv
// Shared state encoding, width helpers and memory-map defaults for the
// round-robin Wishbone interconnect and its arbiter.
package wb_rr_interconnect_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } icn_state_e;

  localparam int unsigned SOC_SLV_SHIFT = 28;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(n)) r = i + 1;
    end
    return r;
  endfunction

  function automatic int unsigned sel_width(input int unsigned n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter: one-hot pick scanning upward from the last winner;
// the pointer only advances when enabled and a request was granted.
module wb_rr_arbiter
  import wb_rr_interconnect_pkg::*;
#(
  parameter  int unsigned NM = 2,
  localparam int unsigned PW = sel_width(NM)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [NM-1:0] req,
  output logic [NM-1:0] grant,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] cand;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NM; k++) begin
      cand = PW'((32'(ptr) + k) % NM);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Reset to the last master so master 0 wins the first arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= PW'(NM - 1);
    end else if (en && found) begin
      ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/wb_rr_interconnect.sv
// Shared-bus Wishbone classic interconnect: NM masters, NS slaves, round-robin grant,
// address-field decode with error on miss. Define WB_ICN_TIMEOUT_EN for the stall watchdog.
module wb_rr_interconnect
  import wb_rr_interconnect_pkg::*;
#(
  parameter int unsigned NM        = 2,
  parameter int unsigned NS        = 3,
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned SLV_SHIFT = SOC_SLV_SHIFT,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic             clk,
  input  logic             RESET_N,
  input  logic [NM-1:0]    m_cyc,
  input  logic [NM-1:0]    m_stb,
  input  logic [NM-1:0]    m_we,
  input  logic [NM*AW-1:0] m_adr,
  input  logic [NM*DW-1:0] m_wdata,
  output logic [NM*DW-1:0] m_rdata,
  output logic [NM-1:0]    m_ack,
  output logic [NM-1:0]    m_err,
  output logic [NS-1:0]    s_cyc,
  output logic [NS-1:0]    s_stb,
  output logic             s_we,
  output logic [AW-1:0]    s_adr,
  output logic [DW-1:0]    s_wdata,
  input  logic [NS*DW-1:0] s_rdata,
  input  logic [NS-1:0]    s_ack
);

  localparam int unsigned PW   = sel_width(NM);
  localparam int unsigned SELW = sel_width(NS);

  icn_state_e      state, state_d;
  logic [NM-1:0]   gnt_q, arb_grant, req;
  logic [PW-1:0]   gidx, arb_idx;
  logic            arb_en, busy, cyc_g, stb_g, we_g, miss, fwd, ack_s, err_q, tmo_hit;
  logic [AW-1:0]   adr_g;
  logic [DW-1:0]   wdata_g, rdata_s;
  logic [SELW-1:0] sel;
  logic [AW-1:0]   adr_a   [NM];
  logic [DW-1:0]   wdata_a [NM];
  logic [DW-1:0]   rdata_a [NS];

  for (genvar i = 0; i < NM; i++) begin : g_mst
    assign adr_a[i]   = m_adr[i*AW +: AW];
    assign wdata_a[i] = m_wdata[i*DW +: DW];
    assign m_rdata[i*DW +: DW] = (busy && gnt_q[i]) ? rdata_s : '0;
  end

  for (genvar j = 0; j < NS; j++) begin : g_slv
    assign rdata_a[j] = s_rdata[j*DW +: DW];
  end

  assign req  = m_cyc & m_stb;
  assign busy = (state == ST_BUSY);

  wb_rr_arbiter #(.NM(NM)) u_arb (
    .clk       (clk),
    .rst_n     (RESET_N),
    .en        (arb_en),
    .req       (req),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // Granted-master view; decode is recomputed every cycle from the live address.
  always_comb begin
    cyc_g   = m_cyc[gidx];
    stb_g   = m_stb[gidx];
    we_g    = m_we[gidx];
    adr_g   = adr_a[gidx];
    wdata_g = wdata_a[gidx];
    sel     = adr_g[SLV_SHIFT +: SELW];
    miss    = (32'(sel) >= NS);
    rdata_s = miss ? '0 : rdata_a[sel];
  end

`ifdef WB_ICN_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  assign tmo_hit = (state == ST_BUSY) && (tmo_cnt == 8'(TIMEOUT));

  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      tmo_cnt <= '0;
    end else if (!busy || ack_s || err_q || tmo_hit) begin
      tmo_cnt <= '0;
    end else if (cyc_g && stb_g) begin
      tmo_cnt <= tmo_cnt + 8'd1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    fwd     = busy && cyc_g && !miss && !tmo_hit;
    ack_s   = fwd && s_ack[sel];
    s_cyc   = fwd ? (NS'(1) << sel) : '0;
    s_stb   = (fwd && stb_g) ? (NS'(1) << sel) : '0;
    s_we    = busy && we_g;
    s_adr   = busy ? adr_g : '0;
    s_wdata = busy ? wdata_g : '0;
    m_ack   = gnt_q & {NM{ack_s}};
    m_err   = gnt_q & {NM{err_q | tmo_hit}};
  end

  always_comb begin
    state_d = state;
    arb_en  = 1'b0;
    unique case (state)
      ST_IDLE: if (|req) begin
        arb_en  = 1'b1;
        state_d = ST_BUSY;
      end
      ST_BUSY: if (!cyc_g) state_d = ST_IDLE;
    endcase
  end

  // err_q self-clears so a held strobe on a miss sees one pulse per access.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= ST_IDLE;
      gnt_q <= '0;
      gidx  <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_d;
      err_q <= busy && cyc_g && stb_g && miss && !err_q;
      if (arb_en) begin
        gnt_q <= arb_grant;
        gidx  <= arb_idx;
      end
    end
  end

endmodule
